bram_read_arbiter: RTL and testbench
====================================

// Module: bram_read_arbiter
// PURPOSE
//  Shares the single read port of the instruction BRAM between BB_N regex coprocessors and the
//  host command path (CMD_READ). Host has fixed priority; coprocessors are served round-robin.
//  Sits between the coprocessor array and bram, and routes each read response to its requester.
//  Counts stall cycles for software-visible performance monitoring.
// PARAMETERS
//  BB_N        4   number of coprocessor requesters (>=1)
//  ADDR_WIDTH  9   BRAM read address width
//  DATA_WIDTH  64  BRAM read data width
//  REG_WIDTH   32  width of the stall counter (AXI_package value)
// PORTS
//  clk           in   1              clock
//  rst_n         in   1              asynchronous reset, active-low
//  enable        in   1              1: coprocessor grants allowed; 0: only host served
//  clear_stats   in   1              synchronous clear of stall_cc
//  req_valid     in   BB_N           coprocessor i requests a read
//  req_addr      in   BB_N*ADDR_W    address of requester i, slice [i*ADDR_WIDTH+:ADDR_WIDTH]
//  req_ready     out  BB_N           one-hot grant; request i accepted this cycle
//  rsp_valid     out  BB_N           one-hot; rsp_data belongs to requester i this cycle
//  rsp_data      out  DATA_WIDTH     shared response bus (BRAM data passed through)
//  host_valid    in   1              host read request
//  host_addr     in   ADDR_WIDTH     host read address
//  host_ready    out  1              host request accepted this cycle
//  host_rsp_valid out 1              rsp_data belongs to host this cycle
//  bram_r_addr   out  ADDR_WIDTH     to bram read address
//  bram_r_valid  out  1              to bram read enable
//  bram_r_data   in   DATA_WIDTH     from bram, valid one cycle after bram_r_valid
//  stall_cc      out  REG_WIDTH      saturating count of cycles with >=1 requester denied
// BEHAVIOUR
//  - Reset (rst_n=0, any time): rr_ptr=0, rsp_valid=0, host_rsp_valid=0, stall_cc=0; in-flight
//    response dropped (never delivered after reset deasserts).
//  - Arbitration is combinational within the cycle; at most one grant per cycle.
//  - host_valid=1 -> host_ready=1, bram_r_addr=host_addr, all req_ready=0, rr_ptr unchanged.
//  - Else if enable=1 and |req_valid: grant the first i with req_valid[i] searching
//    rr_ptr, rr_ptr+1, ... mod BB_N; req_ready[i]=1, bram_r_addr=req_addr slice i;
//    rr_ptr <= (i+1) mod BB_N on the next edge.
//  - Else: no grant, bram_r_valid=0, bram_r_addr=0, rr_ptr unchanged.
//  - bram_r_valid = host_ready | (|req_ready).
//  - Response: registered grant vector g_q; rsp_valid = g_q[BB_N-1:0], host_rsp_valid = g_q host
//    bit, exactly one cycle after the grant. rsp_data = bram_r_data (no extra register).
//  - Requester holding valid without ready must keep addr stable; arbiter never grants a
//    request whose req_valid is 0. Dropping valid before grant is legal (request withdrawn).
//  - Fairness: with all BB_N requesting continuously and no host, each is granted once every
//    BB_N cycles. Back-to-back grants to the same requester only when it is the sole requester.
//  - enable=0 mid-stream: pending response of a grant already issued still delivered.
//  - stall_cc: +1 each cycle where (req_valid & ~req_ready)!=0 or (host_valid & ~host_ready);
//    saturates at all-ones; clear_stats has priority over increment.
//  - BB_N=1: rr_ptr is constant 0; behaviour otherwise identical.
// STRUCTURE
//  - AXI_package: REG_WIDTH; add typedef arb_grant_t (BB_N+1 bits, host in MSB).
//  - Sub-module rr_pick (combinational): inputs req vector + pointer, outputs one-hot grant and
//    granted index; instantiated once. State (rr_ptr, g_q, stall_cc) lives in the top.
// TESTING
//  1 Reset: rst_n=0 mid-grant with req_valid=4'b1111 -> next cycle rsp_valid=0, stall_cc=0, rr_ptr=0.
//  2 BB_N=4, req_valid=4'b1111 held 8 cycles, enable=1 -> grants 0,1,2,3,0,1,2,3; each
//    rsp_valid one cycle later with rsp_data = mem[addr_i].
//  3 host_valid=1 with req_valid=4'b0110 for 3 cycles -> host granted 3x, rr order resumes at 1
//    then 2; stall_cc increases by 3 then 1 then 0 per cycle.
//  4 req_valid=4'b0100 only, held 5 cycles -> requester 2 granted every cycle, stall_cc unchanged.
//  5 enable=0, req_valid=4'b1111, host_valid=0 -> no grants, bram_r_valid=0, stall_cc +1/cycle;
//    preload stall_cc near all-ones via long run -> saturates, clear_stats -> 0.
//  6 Random requests/withdrawals 10k cycles vs. reference model -> one-hot grants, every response
//    matches addressed word, no requester waits more than BB_N grant slots without host traffic.

Source files
------------

// File: rtl/bram_read_arbiter_pkg.sv
// Shared constants and types for the instruction-BRAM read arbiter.
// Grant vectors carry one bit per coprocessor plus the host in the MSB.
package bram_read_arbiter_pkg;

   localparam int BB_N_DEF       = 4;
   localparam int ADDR_WIDTH_DEF = 9;
   localparam int DATA_WIDTH_DEF = 64;
   localparam int REG_WIDTH_DEF  = 32;

   typedef logic [BB_N_DEF:0] arb_grant_t;

   // Pointer width that stays legal when only one coprocessor exists.
   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bram_read_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping; zero latency.
// Purely combinational, no backpressure of its own.
module bram_read_arbiter_rr_pick
   import bram_read_arbiter_pkg::*;
#(
   parameter int N  = BB_N_DEF,
   parameter int PW = ptr_width(N)
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [PW-1:0] idx,
   output logic          any
);

   always_comb begin
      int j;
      j   = 0;
      gnt = '0;
      idx = '0;
      any = 1'b0;
      for (int k = 0; k < N; k++) begin
         j = (int'(ptr) + k) % N;
         if (!any && req[j]) begin
            any    = 1'b1;
            gnt[j] = 1'b1;
            idx    = PW'(j);
         end
      end
   end

endmodule

// File: rtl/bram_read_arbiter.sv
// Shares the BRAM read port between host (fixed priority) and BB_N coprocessors (round-robin); grant is same-cycle, response one cycle later.
// Backpressure: a denied requester sees ready low and must hold valid/addr; every cycle with a denied requester bumps stall_cc.
module bram_read_arbiter
   import bram_read_arbiter_pkg::*;
#(
   parameter int BB_N       = BB_N_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int REG_WIDTH  = REG_WIDTH_DEF
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       enable,
   input  logic                       clear_stats,
   input  logic [BB_N-1:0]            req_valid,
   input  logic [BB_N*ADDR_WIDTH-1:0] req_addr,
   output logic [BB_N-1:0]            req_ready,
   output logic [BB_N-1:0]            rsp_valid,
   output logic [DATA_WIDTH-1:0]      rsp_data,
   input  logic                       host_valid,
   input  logic [ADDR_WIDTH-1:0]      host_addr,
   output logic                       host_ready,
   output logic                       host_rsp_valid,
   output logic [ADDR_WIDTH-1:0]      bram_r_addr,
   output logic                       bram_r_valid,
   input  logic [DATA_WIDTH-1:0]      bram_r_data,
   output logic [REG_WIDTH-1:0]       stall_cc
);

   localparam int PW = ptr_width(BB_N);

   logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
   logic [BB_N:0]        g_q, g_d;
   logic [REG_WIDTH-1:0] stall_cc_q, stall_cc_d;

   logic [BB_N-1:0] pick_gnt;
   logic [PW-1:0]   pick_idx;
   logic            pick_any;
   logic            stall_ev;

   bram_read_arbiter_rr_pick #(.N(BB_N), .PW(PW)) u_pick (
      .req (req_valid & {BB_N{enable}}),
      .ptr (rr_ptr_q),
      .gnt (pick_gnt),
      .idx (pick_idx),
      .any (pick_any)
   );

   always_comb begin
      host_ready  = host_valid;
      req_ready   = '0;
      bram_r_addr = '0;
      rr_ptr_d    = rr_ptr_q;
      if (host_valid) begin
         bram_r_addr = host_addr;
      end else if (pick_any) begin
         req_ready   = pick_gnt;
         bram_r_addr = req_addr[int'(pick_idx)*ADDR_WIDTH +: ADDR_WIDTH];
         rr_ptr_d    = (int'(pick_idx) == BB_N-1) ? '0 : pick_idx + PW'(1);
      end
      bram_r_valid = host_ready | (|req_ready);
      g_d          = {host_ready, req_ready};
   end

   // Clear wins over a simultaneous stall; the counter sticks at all-ones.
   always_comb begin
      stall_ev   = (|(req_valid & ~req_ready)) | (host_valid & ~host_ready);
      stall_cc_d = stall_cc_q;
      if (clear_stats)
         stall_cc_d = '0;
      else if (stall_ev && !(&stall_cc_q))
         stall_cc_d = stall_cc_q + REG_WIDTH'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q   <= '0;
         g_q        <= '0;
         stall_cc_q <= '0;
      end else begin
         rr_ptr_q   <= rr_ptr_d;
         g_q        <= g_d;
         stall_cc_q <= stall_cc_d;
      end
   end

   assign rsp_valid      = g_q[BB_N-1:0];
   assign host_rsp_valid = g_q[BB_N];
   assign rsp_data       = bram_r_data;
   assign stall_cc       = stall_cc_q;

endmodule

// File: tb/tb_bram_read_arbiter.sv
// Directed vector table plus reset, saturation and randomized sequences for bram_read_arbiter.
// A behavioural BRAM returns a pure function of the address so every response can be predicted.
module tb_bram_read_arbiter;

   localparam int N  = 4;
   localparam int AW = 9;
   localparam int DW = 64;
   localparam int RW = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          enable;
   logic          clear_stats;
   logic [N-1:0]  req_valid;
   logic [N*AW-1:0] req_addr;
   logic [N-1:0]  req_ready;
   logic [N-1:0]  rsp_valid;
   logic [DW-1:0] rsp_data;
   logic          host_valid;
   logic [AW-1:0] host_addr;
   logic          host_ready;
   logic          host_rsp_valid;
   logic [AW-1:0] bram_r_addr;
   logic          bram_r_valid;
   logic [DW-1:0] bram_r_data;
   logic [RW-1:0] stall_cc;

   bram_read_arbiter #(.BB_N(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .REG_WIDTH(RW)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .enable         (enable),
      .clear_stats    (clear_stats),
      .req_valid      (req_valid),
      .req_addr       (req_addr),
      .req_ready      (req_ready),
      .rsp_valid      (rsp_valid),
      .rsp_data       (rsp_data),
      .host_valid     (host_valid),
      .host_addr      (host_addr),
      .host_ready     (host_ready),
      .host_rsp_valid (host_rsp_valid),
      .bram_r_addr    (bram_r_addr),
      .bram_r_valid   (bram_r_valid),
      .bram_r_data    (bram_r_data),
      .stall_cc       (stall_cc)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] word(input logic [AW-1:0] a);
      return {7'h5A, a, 16'hBEEF, 32'(a) * 32'h9E37_79B1};
   endfunction

   always @(posedge clk) if (bram_r_valid) bram_r_data <= word(bram_r_addr);

   typedef struct {
      logic         hv;
      logic         en;
      logic [N-1:0] rv;
      logic [N:0]   g;
      logic         d;
   } vec_t;
   vec_t tbl[$];

   int          n_cmp = 0;
   int          n_err = 0;
   int          exp_stall = 0;
   logic [N:0]  prev_g = '0;
   logic [AW-1:0] prev_addr = '0;
   int          m_ptr = 0;
   int          wait_cnt[N];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic add(input logic hv, input logic en, input logic [N-1:0] rv,
                      input logic [N:0] g, input logic d);
      vec_t v;
      v.hv = hv; v.en = en; v.rv = rv; v.g = g; v.d = d;
      tbl.push_back(v);
   endtask

   // One clock: check last cycle's response, this cycle's grant/address/counter, then advance.
   task automatic tick(input logic [N:0] eg, input logic d, input logic clr);
      logic [AW-1:0] ea;
      @(negedge clk);
      chk("rsp_valid", 64'(rsp_valid), 64'(prev_g[N-1:0]));
      chk("host_rsp_valid", 64'(host_rsp_valid), 64'(prev_g[N]));
      if (prev_g != '0) chk("rsp_data", rsp_data, word(prev_addr));
      ea = '0;
      if (eg[N]) ea = host_addr;
      else for (int i = 0; i < N; i++) if (eg[i]) ea = req_addr[i*AW +: AW];
      chk("grant", 64'({host_ready, req_ready}), 64'(eg));
      chk("bram_r_valid", 64'(bram_r_valid), 64'(|eg));
      chk("bram_r_addr", 64'(bram_r_addr), 64'(ea));
      chk("stall_cc", 64'(stall_cc), 64'(exp_stall));
      if (clr) exp_stall = 0;
      else if (d && exp_stall < 255) exp_stall++;
      prev_g    = eg;
      prev_addr = ea;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; enable = 1'b0; clear_stats = 1'b0;
      req_valid = '0; host_valid = 1'b0; host_addr = '0;
      for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = AW'(17 + 100*i);
      for (int i = 0; i < N; i++) wait_cnt[i] = 0;

      // coprocessor round-robin, host priority, sole requester, enable off, wrap-around
      for (int k = 0; k < 8; k++) add(0, 1, 4'b1111, 5'b00001 << (k % 4), 1);
      for (int k = 0; k < 3; k++) add(1, 1, 4'b0110, 5'b10000, 1);
      add(0, 1, 4'b0110, 5'b00010, 1);
      for (int k = 0; k < 6; k++) add(0, 1, 4'b0100, 5'b00100, 0);
      add(0, 1, 4'b1001, 5'b01000, 1);
      for (int k = 0; k < 3; k++) add(0, 0, 4'b1111, 5'b00000, 1);
      add(1, 0, 4'b1111, 5'b10000, 1);
      add(0, 0, 4'b0000, 5'b00000, 0);
      add(0, 1, 4'b1001, 5'b00001, 1);
      add(0, 1, 4'b0000, 5'b00000, 0);
      add(1, 1, 4'b0000, 5'b10000, 0);
      add(0, 1, 4'b1000, 5'b01000, 0);

      #3;
      chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("reset_host_rsp", 64'(host_rsp_valid), 64'd0);
      chk("reset_stall", 64'(stall_cc), 64'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Reset while a response is in flight: it must never appear, pointer returns to 0.
      enable = 1'b1; req_valid = 4'b1111;
      tick(5'b00001, 1, 0);
      tick(5'b00010, 1, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("midrst_stall", 64'(stall_cc), 64'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      prev_g = '0; exp_stall = 0;

      for (int k = 0; k < tbl.size(); k++) begin
         host_valid = tbl[k].hv;
         host_addr  = AW'(9'h100 + k);
         enable     = tbl[k].en;
         req_valid  = tbl[k].rv;
         tick(tbl[k].g, tbl[k].d, 0);
      end

      // Saturation and clear priority.
      host_valid = 1'b0; enable = 1'b0; req_valid = 4'b1111;
      clear_stats = 1'b1; tick('0, 1, 1);
      clear_stats = 1'b0;
      repeat (260) tick('0, 1, 0);
      clear_stats = 1'b1; tick('0, 1, 1);
      clear_stats = 1'b0; tick('0, 1, 0);
      req_valid = '0; tick('0, 0, 0);

      // Randomized traffic against a reference arbiter; pointer is 0 after the table.
      m_ptr = 0;
      for (int c = 0; c < 3000; c++) begin
         logic [N:0] eg;
         logic       d;
         for (int i = 0; i < N; i++) begin
            if (req_valid[i] && !prev_g[i]) begin
               if ($urandom_range(15) == 0) begin
                  req_valid[i] = 1'b0;
                  wait_cnt[i]  = 0;
               end
            end else begin
               req_valid[i] = 1'($urandom_range(1));
               req_addr[i*AW +: AW] = AW'($urandom_range(511));
               wait_cnt[i] = 0;
            end
         end
         host_valid = ($urandom_range(7) == 0);
         host_addr  = AW'($urandom_range(511));
         enable     = ($urandom_range(15) != 0);
         eg = '0;
         if (host_valid) eg[N] = 1'b1;
         else if (enable) begin
            for (int k = 0; k < N; k++) begin
               int j;
               j = (m_ptr + k) % N;
               if (req_valid[j] && eg == '0) begin
                  eg[j] = 1'b1;
                  m_ptr = (j + 1) % N;
               end
            end
         end
         if (eg[N-1:0] != '0) begin
            for (int i = 0; i < N; i++) begin
               if (req_valid[i] && !eg[i]) begin
                  wait_cnt[i]++;
                  chk("rr_wait_bound", 64'(wait_cnt[i] < N), 64'd1);
               end
            end
         end
         d = (|(req_valid & ~eg[N-1:0])) | (host_valid & ~eg[N]);
         tick(eg, d, 0);
      end
      req_valid = '0; host_valid = 1'b0;
      tick('0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
